eh2_lsu_ecc_wb_ctl: RTL and testbench

Controller for the LSU DCCM ECC correction path. It queues single-bit-error correction requests from the load pipe at DC5 and arbitrates the DCCM write port between DMA, correction writeback and the store buffer. It also runs a background scrubber that issues periodic DCCM reads so latent single-bit errors are found and repaired. It sits beside the LSU ECC datapath and drives that datapath's write select: the datapath muxes DMA data, then registered SEC data, then store-buffer data.

---
 rtl/eh2_lsu_ecc_wb_ctl_pkg.sv | 23 ++
 rtl/eh2_lsu_ecc_wb_fifo.sv | 66 ++++++
 rtl/eh2_lsu_ecc_wb_ctl.sv | 144 ++++++++++++++
 tb/tb_eh2_lsu_ecc_wb_ctl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_lsu_ecc_wb_ctl_pkg.sv
// Shared types for the LSU DCCM ECC correction writeback controller.
package eh2_lsu_ecc_wb_ctl_pkg;

    // Address field width of a queued correction; matches the default DCCM byte-address width.
    localparam int unsigned ECC_WB_ADDR_W = 16;

    // Scrub reads walk the DCCM one dword at a time.
    localparam int unsigned SCRUB_STRIDE = 8;

    typedef struct packed {
        logic [ECC_WB_ADDR_W-1:0] addr;
        logic                     lo;
        logic                     hi;
    } eh2_ecc_wb_entry_t;

    typedef enum logic [1:0] {
        SCRUB_IDLE,
        SCRUB_WAIT,
        SCRUB_REQ,
        SCRUB_RESP
    } eh2_scrub_state_t;

endpackage

// File: rtl/eh2_lsu_ecc_wb_fifo.sv
// Parameterised FIFO for pending correction writes, with sticky overflow.
module eh2_lsu_ecc_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             ovf_q, ovf_d;
    logic             push_acc;
    logic             pop_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    // A pop frees a slot in the same cycle, so a push into a full queue is accepted alongside it.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    assign dout = empty ? '0 : mem_q[rd_ptr_q[PW-2:0]];
    assign ovf  = ovf_q;

    // Next-state for pointers, storage and overflow flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(push_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop_acc);
        ovf_d    = ovf_q | (push & ~push_acc);
        if (push_acc) begin
            mem_d[wr_ptr_q[PW-2:0]] = din;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/eh2_lsu_ecc_wb_ctl.sv
// DCCM ECC correction queue, write-port arbiter and background scrubber.
module eh2_lsu_ecc_wb_ctl
    import eh2_lsu_ecc_wb_ctl_pkg::*;
#(
    parameter int unsigned DCCM_BITS = 16,
    parameter int unsigned QDEPTH    = 2,
    parameter int unsigned SCRUB_IW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 ld_single_ecc_error_dc5,
    input  logic                 ld_single_ecc_error_lo_dc5,
    input  logic                 ld_single_ecc_error_hi_dc5,
    input  logic [DCCM_BITS-1:0] ld_sec_addr_dc5,
    input  logic                 dec_tlu_core_ecc_disable,
    input  logic                 scrub_en,
    input  logic [SCRUB_IW-1:0]  scrub_interval,
    input  logic [DCCM_BITS-1:0] scrub_last_addr,
    input  logic                 dma_dccm_wen_req,
    input  logic                 stbuf_reqvld_any,
    input  logic                 scrub_rd_gnt,
    input  logic                 scrub_rd_done,
    output logic                 dma_dccm_gnt,
    output logic                 ecc_wr_gnt,
    output logic                 stbuf_gnt,
    output logic [DCCM_BITS-1:0] ecc_wr_addr,
    output logic                 ecc_wr_lo,
    output logic                 ecc_wr_hi,
    output logic                 ecc_q_full,
    output logic                 ecc_q_ovf,
    output logic                 scrub_rd_req,
    output logic [DCCM_BITS-1:0] scrub_rd_addr
);

    eh2_ecc_wb_entry_t push_entry;
    eh2_ecc_wb_entry_t head_entry;
    logic              q_push;
    logic              q_empty;

    eh2_scrub_state_t     state_q, state_d;
    logic [SCRUB_IW-1:0]  cnt_q, cnt_d;
    logic [DCCM_BITS-1:0] addr_q, addr_d;
    logic                 scrub_go;

    assign q_push = ld_single_ecc_error_dc5 & ~dec_tlu_core_ecc_disable;

    // Build the queue entry from the DC5 error report.
    always_comb begin
        push_entry                      = '0;
        push_entry.addr[DCCM_BITS-1:0]  = ld_sec_addr_dc5;
        push_entry.lo                   = ld_single_ecc_error_lo_dc5;
        push_entry.hi                   = ld_single_ecc_error_hi_dc5;
    end

    eh2_lsu_ecc_wb_fifo #(
        .WIDTH ($bits(eh2_ecc_wb_entry_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (q_push),
        .pop   (ecc_wr_gnt),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (ecc_q_full),
        .empty (q_empty),
        .ovf   (ecc_q_ovf)
    );

    assign ecc_wr_addr = head_entry.addr[DCCM_BITS-1:0];
    assign ecc_wr_lo   = head_entry.lo;
    assign ecc_wr_hi   = head_entry.hi;

    // Fixed-priority write-port arbitration: DMA, then correction, then store buffer.
    always_comb begin
        dma_dccm_gnt = dma_dccm_wen_req;
        ecc_wr_gnt   = ~dma_dccm_wen_req & ~q_empty;
        stbuf_gnt    = ~dma_dccm_wen_req & q_empty & stbuf_reqvld_any;
    end

    assign scrub_go      = scrub_en & ~dec_tlu_core_ecc_disable;
    assign scrub_rd_req  = (state_q == SCRUB_REQ);
    assign scrub_rd_addr = addr_q;

    // Scrubber next-state, interval counter and read address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            SCRUB_IDLE: begin
                if (scrub_go) begin
                    state_d = SCRUB_WAIT;
                    cnt_d   = '0;
                end
            end
            SCRUB_WAIT: begin
                if (!scrub_go) begin
                    state_d = SCRUB_IDLE;
                end else begin
                    // Counter saturates so an interval reached while the queue is full is not lost.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + SCRUB_IW'(1);
                    end
                    if ((cnt_q >= scrub_interval) && !ecc_q_full) begin
                        state_d = SCRUB_REQ;
                    end
                end
            end
            SCRUB_REQ: begin
                // A grant in the cycle the scrubber is disabled still completes through RESP.
                if (scrub_rd_gnt) begin
                    state_d = SCRUB_RESP;
                end else if (!scrub_go) begin
                    state_d = SCRUB_IDLE;
                end
            end
            SCRUB_RESP: begin
                if (scrub_rd_done) begin
                    addr_d  = (addr_q >= scrub_last_addr) ? '0 : addr_q + DCCM_BITS'(SCRUB_STRIDE);
                    cnt_d   = '0;
                    state_d = scrub_go ? SCRUB_WAIT : SCRUB_IDLE;
                end
            end
            default: begin
                state_d = SCRUB_IDLE;
            end
        endcase
    end

    // Scrubber registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= SCRUB_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_eh2_lsu_ecc_wb_ctl.sv
// Scoreboard bench for the ECC correction writeback controller.
module tb_eh2_lsu_ecc_wb_ctl;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        ld_single_ecc_error_dc5 = 1'b0;
    logic        ld_single_ecc_error_lo_dc5 = 1'b0;
    logic        ld_single_ecc_error_hi_dc5 = 1'b0;
    logic [15:0] ld_sec_addr_dc5 = '0;
    logic        dec_tlu_core_ecc_disable = 1'b0;
    logic        scrub_en = 1'b0;
    logic [15:0] scrub_interval = '0;
    logic [15:0] scrub_last_addr = '0;
    logic        dma_dccm_wen_req = 1'b0;
    logic        stbuf_reqvld_any = 1'b0;
    logic        scrub_rd_gnt = 1'b0;
    logic        scrub_rd_done = 1'b0;
    logic        dma_dccm_gnt, ecc_wr_gnt, stbuf_gnt;
    logic [15:0] ecc_wr_addr;
    logic        ecc_wr_lo, ecc_wr_hi;
    logic        ecc_q_full, ecc_q_ovf;
    logic        scrub_rd_req;
    logic [15:0] scrub_rd_addr;

    typedef struct packed {
        logic [15:0] addr;
        logic        lo;
        logic        hi;
    } exp_wr_t;

    exp_wr_t     exp_wr[$];
    logic [15:0] exp_scrub[$];
    int          errors = 0;
    int          checks = 0;

    eh2_lsu_ecc_wb_ctl #(
        .DCCM_BITS (16),
        .QDEPTH    (2),
        .SCRUB_IW  (16)
    ) dut (
        .clk                        (clk),
        .rst_l                      (rst_l),
        .ld_single_ecc_error_dc5    (ld_single_ecc_error_dc5),
        .ld_single_ecc_error_lo_dc5 (ld_single_ecc_error_lo_dc5),
        .ld_single_ecc_error_hi_dc5 (ld_single_ecc_error_hi_dc5),
        .ld_sec_addr_dc5            (ld_sec_addr_dc5),
        .dec_tlu_core_ecc_disable   (dec_tlu_core_ecc_disable),
        .scrub_en                   (scrub_en),
        .scrub_interval             (scrub_interval),
        .scrub_last_addr            (scrub_last_addr),
        .dma_dccm_wen_req           (dma_dccm_wen_req),
        .stbuf_reqvld_any           (stbuf_reqvld_any),
        .scrub_rd_gnt               (scrub_rd_gnt),
        .scrub_rd_done              (scrub_rd_done),
        .dma_dccm_gnt               (dma_dccm_gnt),
        .ecc_wr_gnt                 (ecc_wr_gnt),
        .stbuf_gnt                  (stbuf_gnt),
        .ecc_wr_addr                (ecc_wr_addr),
        .ecc_wr_lo                  (ecc_wr_lo),
        .ecc_wr_hi                  (ecc_wr_hi),
        .ecc_q_full                 (ecc_q_full),
        .ecc_q_ovf                  (ecc_q_ovf),
        .scrub_rd_req               (scrub_rd_req),
        .scrub_rd_addr              (scrub_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_err(input logic [15:0] a, input logic lo, input logic hi);
        ld_single_ecc_error_dc5    = 1'b1;
        ld_sec_addr_dc5            = a;
        ld_single_ecc_error_lo_dc5 = lo;
        ld_single_ecc_error_hi_dc5 = hi;
    endtask

    task automatic no_push();
        ld_single_ecc_error_dc5    = 1'b0;
        ld_single_ecc_error_lo_dc5 = 1'b0;
        ld_single_ecc_error_hi_dc5 = 1'b0;
        ld_sec_addr_dc5            = '0;
    endtask

    // Returns at the negedge of the first cycle showing scrub_rd_req; n counts cycles waited.
    task automatic wait_req(output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (scrub_rd_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Monitor: pops expected writes and scrub reads whenever the DUT presents them.
    always @(negedge clk) begin
        exp_wr_t     e;
        logic [15:0] sa;
        if (rst_l) begin
            chk("grant_onehot", 32'($countones({dma_dccm_gnt, ecc_wr_gnt, stbuf_gnt}) <= 1), 32'd1);
            chk("dma_gnt", 32'(dma_dccm_gnt), 32'(dma_dccm_wen_req));
            if (ecc_wr_gnt) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ecc_wr_unexpected: got addr 0x%0h expected no write", ecc_wr_addr);
                end else begin
                    e = exp_wr.pop_front();
                    chk("ecc_wr_addr", 32'(ecc_wr_addr), 32'(e.addr));
                    chk("ecc_wr_lo", 32'(ecc_wr_lo), 32'(e.lo));
                    chk("ecc_wr_hi", 32'(ecc_wr_hi), 32'(e.hi));
                end
            end
            if (scrub_rd_req && scrub_rd_gnt) begin
                if (exp_scrub.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scrub_unexpected: got addr 0x%0h expected no read", scrub_rd_addr);
                end else begin
                    sa = exp_scrub.pop_front();
                    chk("scrub_rd_addr", 32'(scrub_rd_addr), 32'(sa));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic ok;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_dma_gnt", 32'(dma_dccm_gnt), 32'd0);
        chk("rst_ecc_gnt", 32'(ecc_wr_gnt), 32'd0);
        chk("rst_stbuf_gnt", 32'(stbuf_gnt), 32'd0);
        chk("rst_wr_addr", 32'(ecc_wr_addr), 32'd0);
        chk("rst_full", 32'(ecc_q_full), 32'd0);
        chk("rst_ovf", 32'(ecc_q_ovf), 32'd0);
        chk("rst_scrub_req", 32'(scrub_rd_req), 32'd0);
        chk("rst_scrub_addr", 32'(scrub_rd_addr), 32'd0);
        step();
        rst_l = 1'b1;
        step();

        // Single correction with store buffer contending
        stbuf_reqvld_any = 1'b1;
        push_err(16'h0040, 1'b1, 1'b0);
        exp_wr.push_back('{16'h0040, 1'b1, 1'b0});
        @(negedge clk);
        chk("t1_stbuf_gnt_empty", 32'(stbuf_gnt), 32'd1);
        chk("t1_ecc_gnt_same_cycle", 32'(ecc_wr_gnt), 32'd0);
        step();
        no_push();
        @(negedge clk);
        chk("t1_ecc_gnt_next", 32'(ecc_wr_gnt), 32'd1);
        chk("t1_stbuf_blocked", 32'(stbuf_gnt), 32'd0);
        step();
        @(negedge clk);
        chk("t1_ecc_gnt_drained", 32'(ecc_wr_gnt), 32'd0);
        chk("t1_stbuf_gnt_again", 32'(stbuf_gnt), 32'd1);
        stbuf_reqvld_any = 1'b0;
        step();

        // DMA holds the port for three cycles
        dma_dccm_wen_req = 1'b1;
        push_err(16'h0080, 1'b0, 1'b1);
        exp_wr.push_back('{16'h0080, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_dma_gnt", 32'(dma_dccm_gnt), 32'd1);
            chk("t2_ecc_blocked", 32'(ecc_wr_gnt), 32'd0);
            step();
            no_push();
        end
        dma_dccm_wen_req = 1'b0;
        @(negedge clk);
        chk("t2_ecc_gnt_cycle4", 32'(ecc_wr_gnt), 32'd1);
        step();

        // Fill to QDEPTH=2 under DMA, third push overflows
        dma_dccm_wen_req = 1'b1;
        push_err(16'h0100, 1'b1, 1'b0);
        exp_wr.push_back('{16'h0100, 1'b1, 1'b0});
        step();
        push_err(16'h0108, 1'b0, 1'b1);
        exp_wr.push_back('{16'h0108, 1'b0, 1'b1});
        step();
        @(negedge clk);
        chk("t3_full_after_2", 32'(ecc_q_full), 32'd1);
        chk("t3_ovf_before_3", 32'(ecc_q_ovf), 32'd0);
        push_err(16'h0110, 1'b1, 1'b1);
        step();
        no_push();
        @(negedge clk);
        chk("t3_ovf_set", 32'(ecc_q_ovf), 32'd1);
        chk("t3_still_full", 32'(ecc_q_full), 32'd1);
        step();

        // Full queue: push and pop together keeps count and order
        dma_dccm_wen_req = 1'b0;
        push_err(16'h0118, 1'b1, 1'b1);
        exp_wr.push_back('{16'h0118, 1'b1, 1'b1});
        @(negedge clk);
        chk("t4_pop_while_full", 32'(ecc_wr_gnt), 32'd1);
        step();
        no_push();
        @(negedge clk);
        chk("t4_full_kept", 32'(ecc_q_full), 32'd1);
        step();
        @(negedge clk);
        chk("t4_full_cleared", 32'(ecc_q_full), 32'd0);
        step();
        @(negedge clk);
        chk("t4_drained", 32'(ecc_wr_gnt), 32'd0);
        chk("t4_ovf_sticky", 32'(ecc_q_ovf), 32'd1);
        step();

        // ECC disable blocks pushes
        dec_tlu_core_ecc_disable = 1'b1;
        push_err(16'h0200, 1'b1, 1'b0);
        step();
        no_push();
        dec_tlu_core_ecc_disable = 1'b0;
        @(negedge clk);
        chk("t5_disabled_no_wr", 32'(ecc_wr_gnt), 32'd0);
        step();

        // Mid-operation reset discards queued corrections and clears overflow
        dma_dccm_wen_req = 1'b1;
        push_err(16'h0300, 1'b1, 1'b0);
        step();
        no_push();
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        dma_dccm_wen_req = 1'b0;
        @(negedge clk);
        chk("t6_rst_no_wr", 32'(ecc_wr_gnt), 32'd0);
        chk("t6_rst_ovf", 32'(ecc_q_ovf), 32'd0);
        chk("t6_rst_addr", 32'(ecc_wr_addr), 32'd0);
        step();
        @(negedge clk);
        chk("t6_rst_still_no_wr", 32'(ecc_wr_gnt), 32'd0);
        step();

        // Scrubber: interval 3, wrap after 0x0010
        scrub_interval  = 16'd3;
        scrub_last_addr = 16'h0010;
        exp_scrub.push_back(16'h0000);
        exp_scrub.push_back(16'h0008);
        exp_scrub.push_back(16'h0010);
        exp_scrub.push_back(16'h0000);
        scrub_en = 1'b1;
        step();
        for (int r = 0; r < 4; r++) begin
            wait_req(n, ok);
            chk("scrub_req_seen", 32'(ok), 32'd1);
            if (!ok) break;
            chk("scrub_wait_cycles", 32'(n), 32'd4);
            step();
            @(negedge clk);
            chk("scrub_req_held", 32'(scrub_rd_req), 32'd1);
            scrub_rd_gnt = 1'b1;
            step();
            scrub_rd_gnt  = 1'b0;
            scrub_rd_done = 1'b1;
            step();
            scrub_rd_done = 1'b0;
        end

        // Drop scrub_en while a request is pending
        wait_req(n, ok);
        chk("t8_req_seen", 32'(ok), 32'd1);
        chk("t8_req_addr", 32'(scrub_rd_addr), 32'h0008);
        step();
        scrub_en = 1'b0;
        step();
        @(negedge clk);
        chk("t8_req_dropped", 32'(scrub_rd_req), 32'd0);
        chk("t8_addr_held", 32'(scrub_rd_addr), 32'h0008);
        step();
        @(negedge clk);
        chk("t8_stays_idle", 32'(scrub_rd_req), 32'd0);

        chk("sb_wr_drained", 32'(exp_wr.size()), 32'd0);
        chk("sb_scrub_drained", 32'(exp_scrub.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
